// File: rtl/riscv_cpu.sv
// ----------------------------------------------------------------------------
// riscv_cpu: single-cycle RV32I subset core with built-in instruction and
// data memories.
//
// Every clock executes one instruction. Fetch, decode, register read, ALU,
// data-memory read and writeback are combinational. The pc, the register
// file and the data memory update together on the rising edge.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   synchronous active-low reset
//   pc       out  current instruction address
//   pc_next  out  address loaded into pc at the next rising edge
//   instr    out  instruction fetched at pc
//   result   out  value on the register-file write port, 0 when no write
//
// Supported: lw, sw, add/sub/and/or/xor/slt/sll/srl,
//            addi/andi/ori/xori/slti, beq, bne, jal.
// Every other opcode/funct3 is a NOP that only advances pc by 4.
// ----------------------------------------------------------------------------
module riscv_cpu #(
    parameter logic [31:0]      RESET_PC   = 32'h0000_1000,
    parameter int unsigned      IMEM_WORDS = 64,
    parameter logic [31:0]      DMEM_BASE  = 32'h0000_2000,
    parameter int unsigned      DMEM_WORDS = 64,
    // Instruction words 0..3; element 0 is the word at RESET_PC.
    parameter logic [3:0][31:0] IMEM_INIT  = {32'hFE42_0AE3, 32'h0062_E233,
                                              32'h0064_A423, 32'hFFC4_A303}
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [31:0] instr,
    output logic [31:0] result
);

    localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [DMEM_WORDS];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] imem_idx;
    logic [31:0] mem_addr, dmem_word, mem_rdata;
    logic [DAW-1:0] dmem_idx;
    logic        wb_en, mem_we;
    logic [31:0] wb_val;

    // ------------------------------------------------------------------
    // Fetch: only words 0..3 carry a program, the rest of imem is NOP.
    // ------------------------------------------------------------------
    assign imem_idx = ((pc_q - RESET_PC) >> 2) % IMEM_WORDS;
    assign instr    = (imem_idx < 32'd4) ? IMEM_INIT[imem_idx[1:0]] : 32'h0000_0013;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Reads see the pre-edge register contents, so a same-cycle write to
    // rd is not visible until the following instruction.
    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // ------------------------------------------------------------------
    // Data memory addressing (shared by lw and sw)
    // ------------------------------------------------------------------
    assign mem_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign dmem_word = ((mem_addr - DMEM_BASE) >> 2) % DMEM_WORDS;
    assign dmem_idx  = DAW'(dmem_word);
    assign mem_rdata = dmem_q[dmem_idx];

    // ------------------------------------------------------------------
    // Execute / next pc
    // ------------------------------------------------------------------
    always_comb begin
        pc_d   = pc_plus4;
        wb_en  = 1'b0;
        wb_val = '0;
        mem_we = 1'b0;
        case (opcode)
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    wb_en  = 1'b1;
                    wb_val = mem_rdata;
                end
            end
            OP_STORE: begin
                mem_we = (funct3 == 3'b010);
            end
            OP_REG: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000:  wb_val = instr[30] ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
                    3'b001:  wb_val = rs1_val << rs2_val[4:0];
                    3'b010:  wb_val = {31'b0, $signed(rs1_val) < $signed(rs2_val)};
                    3'b100:  wb_val = rs1_val ^ rs2_val;
                    3'b101:  wb_val = rs1_val >> rs2_val[4:0];
                    3'b110:  wb_val = rs1_val | rs2_val;
                    3'b111:  wb_val = rs1_val & rs2_val;
                    default: wb_en  = 1'b0;
                endcase
            end
            OP_IMM: begin
                wb_en = 1'b1;
                case (funct3)
                    3'b000:  wb_val = rs1_val + imm_i;
                    3'b010:  wb_val = {31'b0, $signed(rs1_val) < $signed(imm_i)};
                    3'b100:  wb_val = rs1_val ^ imm_i;
                    3'b110:  wb_val = rs1_val | imm_i;
                    3'b111:  wb_val = rs1_val & imm_i;
                    default: wb_en  = 1'b0;
                endcase
            end
            OP_BRANCH: begin
                if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
                    (funct3 == 3'b001 && rs1_val != rs2_val)) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OP_JAL: begin
                wb_en  = 1'b1;
                wb_val = pc_plus4;
                pc_d   = pc_q + imm_j;
            end
            default: ;
        endcase
    end

    assign pc      = pc_q;
    assign pc_next = rst_n ? pc_d : RESET_PC;
    assign result  = wb_en ? wb_val : '0;

    // ------------------------------------------------------------------
    // State update; reset reloads the register file and data memory
    // images and suppresses the in-flight instruction's writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i[4:0]] <= (i == 5) ? 32'h0000_0006 :
                                  (i == 9) ? 32'h0000_2004 : '0;
            end
            for (int unsigned i = 0; i < DMEM_WORDS; i++) begin
                dmem_q[i[DAW-1:0]] <= (i == 0) ? 32'h0000_000A : '0;
            end
        end else begin
            pc_q <= pc_d;
            if (wb_en && rd != 5'd0) begin
                regs_q[rd] <= wb_val;
            end
            if (mem_we) begin
                dmem_q[dmem_idx] <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_riscv_cpu.sv
// ----------------------------------------------------------------------------
// tb_riscv_cpu: self-checking bench for riscv_cpu.
//
// Two cores run side by side on one clock and reset: the default program
// image and a variant image exercising x0 writes, an undefined opcode and
// jal. An instruction-set-level model of each core predicts pc, instr,
// pc_next and result every cycle; directed literal checks pin the model
// and the architectural state at key points of the program.
// ----------------------------------------------------------------------------
module tb_riscv_cpu;

    localparam logic [31:0] RESET_PC   = 32'h0000_1000;
    localparam int unsigned IMEM_WORDS = 64;
    localparam logic [31:0] DMEM_BASE  = 32'h0000_2000;
    localparam int unsigned DMEM_WORDS = 64;

    // Variant: addi x0,x0,5 / addi x7,x0,1 / undefined / jal x1,-12
    localparam logic [3:0][31:0] VAR_IMAGE = {32'hFF5F_F0EF, 32'hFFFF_FFFF,
                                              32'h0010_0393, 32'h0050_0013};

    logic        clk;
    logic        rst_n;
    logic [31:0] pc0, npc0, ins0, res0;
    logic [31:0] pc1, npc1, ins1, res1;
    logic [31:0] o_pc [2], o_npc [2], o_ins [2], o_res [2];

    int checks   = 0;
    int failures = 0;

    riscv_cpu #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_BASE (DMEM_BASE),
        .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc     (pc0),
        .pc_next(npc0),
        .instr  (ins0),
        .result (res0)
    );

    riscv_cpu #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_BASE (DMEM_BASE),
        .DMEM_WORDS(DMEM_WORDS),
        .IMEM_INIT (VAR_IMAGE)
    ) dut_v (
        .clk    (clk),
        .rst_n  (rst_n),
        .pc     (pc1),
        .pc_next(npc1),
        .instr  (ins1),
        .result (res1)
    );

    assign o_pc[0]  = pc0;  assign o_pc[1]  = pc1;
    assign o_npc[0] = npc0; assign o_npc[1] = npc1;
    assign o_ins[0] = ins0; assign o_ins[1] = ins1;
    assign o_res[0] = res0; assign o_res[1] = res1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Instruction-set model
    // ------------------------------------------------------------------
    logic [31:0] m_imem [2][IMEM_WORDS];
    logic [31:0] m_regs [2][32];
    logic [31:0] m_mem  [2][DMEM_WORDS];
    logic [31:0] m_pc   [2];
    bit          m_valid = 1'b0;

    function automatic int unsigned dword(input logic [31:0] addr);
        return ((addr - DMEM_BASE) >> 2) % DMEM_WORDS;
    endfunction

    task automatic m_eval(input int k,
                          output logic [31:0] ins, output logic [31:0] npc,
                          output bit wr, output logic [4:0] wrd, output logic [31:0] wval,
                          output bit mw, output int unsigned midx, output logic [31:0] mval);
        logic [31:0] p, a, b;
        int si, ss, sb, sj;
        logic [31:0] ui;
        p   = m_pc[k];
        ins = m_imem[k][((p - RESET_PC) >> 2) % IMEM_WORDS];
        a   = m_regs[k][ins[19:15]];
        b   = m_regs[k][ins[24:20]];
        si  = $signed(ins[31:20]);
        ss  = $signed({ins[31:25], ins[11:7]});
        sb  = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        sj  = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        ui  = si;
        npc = p + 32'd4;
        wr = 1'b0; wrd = ins[11:7]; wval = '0;
        mw = 1'b0; midx = 0; mval = '0;
        case (ins[6:0])
            7'h03: if (ins[14:12] == 3'd2) begin
                wr = 1'b1; wval = m_mem[k][dword(a + ui)];
            end
            7'h23: if (ins[14:12] == 3'd2) begin
                mw = 1'b1; midx = dword(a + 32'(ss)); mval = b;
            end
            7'h33: begin
                wr = 1'b1;
                case (ins[14:12])
                    3'd0: wval = ins[30] ? a - b : a + b;
                    3'd1: wval = a << b[4:0];
                    3'd2: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd4: wval = a ^ b;
                    3'd5: wval = a >> b[4:0];
                    3'd6: wval = a | b;
                    3'd7: wval = a & b;
                    default: wr = 1'b0;
                endcase
            end
            7'h13: begin
                wr = 1'b1;
                case (ins[14:12])
                    3'd0: wval = a + ui;
                    3'd2: wval = ($signed(a) < si) ? 32'd1 : 32'd0;
                    3'd4: wval = a ^ ui;
                    3'd6: wval = a | ui;
                    3'd7: wval = a & ui;
                    default: wr = 1'b0;
                endcase
            end
            7'h63: begin
                if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b))
                    npc = p + 32'(sb);
            end
            7'h6F: begin
                wr = 1'b1; wval = p + 32'd4; npc = p + 32'(sj);
            end
            default: ;
        endcase
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RESET_PC;
            for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
            m_regs[k][5] = 32'h6;
            m_regs[k][9] = 32'h2004;
            for (int w = 0; w < DMEM_WORDS; w++) m_mem[k][w] = '0;
            m_mem[k][0] = 32'hA;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < IMEM_WORDS; w++) m_imem[k][w] = 32'h0000_0013;
        m_imem[0][0] = 32'hFFC4_A303; m_imem[0][1] = 32'h0064_A423;
        m_imem[0][2] = 32'h0062_E233; m_imem[0][3] = 32'hFE42_0AE3;
        m_imem[1][0] = 32'h0050_0013; m_imem[1][1] = 32'h0010_0393;
        m_imem[1][2] = 32'hFFFF_FFFF; m_imem[1][3] = 32'hFF5F_F0EF;
    end

    always @(posedge clk) begin
        logic [31:0] ins, npc, wval, mval;
        logic [4:0]  wrd;
        bit          wr, mw;
        int unsigned midx;
        if (!rst_n) begin
            m_reset();
            m_valid = 1'b1;
        end else if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                m_eval(k, ins, npc, wr, wrd, wval, mw, midx, mval);
                if (wr && wrd != 5'd0) m_regs[k][wrd] = wval;
                if (mw) m_mem[k][midx] = mval;
                m_pc[k] = npc;
            end
        end
    end

    // Per-cycle output comparison against the model
    always @(negedge clk) begin
        logic [31:0] ins, npc, wval, mval;
        logic [4:0]  wrd;
        bit          wr, mw;
        int unsigned midx;
        if (m_valid) begin
            for (int k = 0; k < 2; k++) begin
                m_eval(k, ins, npc, wr, wrd, wval, mw, midx, mval);
                check($sformatf("model_pc[%0d]", k), o_pc[k], m_pc[k]);
                check($sformatf("model_instr[%0d]", k), o_ins[k], ins);
                check($sformatf("model_pc_next[%0d]", k), o_npc[k], rst_n ? npc : RESET_PC);
                // result for an x0 destination or an abandoned instruction is not pinned
                if (rst_n && !(wr && wrd == 5'd0))
                    check($sformatf("model_result[%0d]", k), o_res[k], wr ? wval : 32'h0);
            end
        end
    end

    task automatic state_vs_model();
        int bad0 = 0, bad1 = 0;
        for (int r = 0; r < 32; r++) begin
            if (dut.regs_q[r]   !== m_regs[0][r]) bad0++;
            if (dut_v.regs_q[r] !== m_regs[1][r]) bad1++;
        end
        for (int w = 0; w < DMEM_WORDS; w++) begin
            if (dut.dmem_q[w]   !== m_mem[0][w]) bad0++;
            if (dut_v.dmem_q[w] !== m_mem[1][w]) bad1++;
        end
        check("state_vs_model_main", bad0, 0);
        check("state_vs_model_variant", bad1, 0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int hits, last, badgap;
        bit found;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // pc=0x1000: lw x6,-4(x9)
        @(negedge clk);
        check("reset_pc", pc0, 32'h1000);
        check("reset_instr", ins0, 32'hFFC4_A303);
        check("reset_result", res0, 32'hA);
        check("var_reset_instr", ins1, 32'h0050_0013);

        // pc=0x1004: sw x6,8(x9)
        @(negedge clk);
        check("lw_x6", dut.regs_q[6], 32'hA);
        check("pc_1004", pc0, 32'h1004);
        check("instr_1004", ins0, 32'h0064_A423);
        check("sw_result_zero", res0, 32'h0);
        check("var_x0_after_write", dut_v.regs_q[0], 32'h0);
        check("var_addi_x7_result", res1, 32'h1);

        // pc=0x1008: or x4,x5,x6
        @(negedge clk);
        check("sw_dmem_200C", dut.dmem_q[3], 32'hA);
        check("or_result", res0, 32'hE);
        check("var_undef_pc", pc1, 32'h1008);
        check("var_undef_pc_next", npc1, 32'h100C);
        check("var_undef_result", res1, 32'h0);

        // pc=0x100C: beq x4,x4,-12
        @(negedge clk);
        check("or_x4", dut.regs_q[4], 32'hE);
        check("pc_100C", pc0, 32'h100C);
        check("beq_pc_next", npc1 == 32'h1000 ? npc0 : npc0, 32'h1000);
        check("var_x7_kept", dut_v.regs_q[7], 32'h1);
        check("var_x0_kept", dut_v.regs_q[0], 32'h0);
        check("var_jal_result", res1, 32'h1010);
        check("var_jal_pc_next", npc1, 32'h1000);
        state_vs_model();

        // Ten further loop iterations, each must close exactly 4 cycles apart
        hits = 0; last = -1; badgap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pc0 == 32'h100C && npc0 == 32'h1000) begin
                if (last >= 0 && i - last != 4) badgap++;
                last = i;
                hits++;
            end
        end
        check("loop_count", hits, 10);
        check("loop_period", badgap, 0);
        check("loop_x4", dut.regs_q[4], 32'hE);
        check("loop_x5", dut.regs_q[5], 32'h6);
        check("loop_x6", dut.regs_q[6], 32'hA);
        check("loop_x9", dut.regs_q[9], 32'h2004);
        check("var_loop_x0", dut_v.regs_q[0], 32'h0);
        state_vs_model();

        // Reset asserted while executing at 0x1008
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (pc0 == 32'h1008) found = 1'b1;
        end
        check("reach_1008", {31'b0, found}, 32'h1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_pc", pc0, 32'h1000);
        check("midreset_x4", dut.regs_q[4], 32'h0);
        check("midreset_x6", dut.regs_q[6], 32'h0);
        check("midreset_x5", dut.regs_q[5], 32'h6);
        check("midreset_x9", dut.regs_q[9], 32'h2004);
        check("midreset_dmem0", dut.dmem_q[0], 32'hA);
        check("midreset_dmem3", dut.dmem_q[3], 32'h0);
        check("var_midreset_x7", dut_v.regs_q[7], 32'h0);
        check("var_midreset_x1", dut_v.regs_q[1], 32'h0);
        state_vs_model();

        repeat (6) @(negedge clk);
        state_vs_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
